// File: rtl/ntt_unload.sv
// Purpose: streams the 2*P-1 NTT product coefficients out as centered signed values.
// Latency: first beat RD_LAT+1 cycles after leaving IDLE, then one beat per cycle.
// Backpressure: reads are credit-limited so the RD_LAT+2 entry FIFO never overflows.
module ntt_unload #(
  parameter int P      = 761,
  parameter int Q      = 4591,
  parameter int PC     = 768,
  parameter int RD_LAT = 4,
  localparam int LG2_Q  = $clog2(Q),
  localparam int LG2_PC = $clog2(PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ntt_valid,
  input  logic [LG2_Q-1:0]  ntt_dout,
  output logic [LG2_PC:0]   ntt_addr,
  output logic              ntt_input_fg,
  output logic [LG2_Q-1:0]  m_data,
  output logic [LG2_PC:0]   m_index,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int AW    = LG2_PC + 1;
  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [AW-1:0]    C_LAST = AW'(2 * P - 2);
  localparam logic [LG2_Q-1:0] C_Q    = LG2_Q'(Q);
  localparam logic [LG2_Q-1:0] C_HALF = LG2_Q'((Q - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE,
    S_WAIT_LOW
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic              r_busy;
  logic              r_done;
  logic [AW-1:0]     r_oidx;
  logic [RD_LAT-1:0] r_tag;
  logic [LG2_Q-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_count;

  logic [CW:0]       w_inflight;
  logic              w_room;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic [LG2_Q-1:0]  w_cent;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads still travelling through the NTT read pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + {{CW{1'b0}}, r_tag[i]};
    end
  end

  // A read may only go out when its data is guaranteed a FIFO slot on return.
  assign w_room  = (w_inflight + {1'b0, r_count}) < (CW + 1)'(DEPTH);
  assign w_issue = (r_state == S_READ) && w_room;
  assign w_push  = r_tag[RD_LAT-1];
  assign w_pop   = m_valid && m_ready;
  assign w_last  = (r_oidx == C_LAST);

  // Map [0,Q) onto the symmetric range around zero before storing.
  assign w_cent = (ntt_dout > C_HALF) ? (ntt_dout - C_Q) : ntt_dout;

  assign ntt_addr     = r_addr;
  assign ntt_input_fg = 1'b0;
  assign m_valid      = (r_count != '0);
  assign m_data       = r_mem[r_rp];
  assign m_index      = r_oidx;
  assign m_last       = m_valid && w_last;
  assign busy         = r_busy;
  assign done         = r_done;

  // Control FSM: owns the read address and the busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          if (ntt_valid) begin
            r_state <= S_READ;
            r_busy  <= 1'b1;
          end
        end
        S_READ: begin
          // The final address is held rather than advanced past the product.
          if (w_issue) begin
            if (r_addr == C_LAST) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // A level that stays high after completion must not start another unload.
          if (!ntt_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Issue tags line up each returning read word with its capture cycle; FIFO buffers it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_tag <= (r_tag << 1) | RD_LAT'(w_issue);
      if (w_push) begin
        r_mem[r_wp] <= w_cent;
        r_wp        <= f_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_inc(r_rp);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output coefficient index advances with each accepted beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_oidx <= '0;
    end else if (r_state == S_IDLE) begin
      r_oidx <= '0;
    end else if (w_pop) begin
      r_oidx <= w_last ? '0 : r_oidx + AW'(1);
    end
  end

endmodule

// File: doc/ntt_unload.md
NTT_UNLOAD -- requirements
Module: ntt_unload

Interface
REQ-001 SHALL have parameter P, default 761: NTRU Prime degree; the product has 2*P-1 coefficients.
REQ-002 SHALL have parameter Q, default 4591: coefficient modulus; LG2_Q = clog2(Q).
REQ-003 SHALL have parameter PC, default 768: NTT cover size; LG2_PC = clog2(PC).
REQ-004 SHALL have parameter RD_LAT, default 4: cycles from ntt_addr to matching ntt_dout.
REQ-005 SHALL have port clk  in  1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1: synchronous, active-low reset.
REQ-007 SHALL have port ntt_valid  in  1: NTT product-ready level.
REQ-008 SHALL have port ntt_dout  in  LG2_Q: NTT read data in [0,Q), unsigned.
REQ-009 SHALL have port ntt_addr  out  LG2_PC+1: NTT read address.
REQ-010 SHALL have port ntt_input_fg  out  1: NTT bank select, held 0 by this block.
REQ-011 SHALL have port m_data  out  LG2_Q: centered signed coefficient.
REQ-012 SHALL have port m_index  out  LG2_PC+1: coefficient index of m_data.
REQ-013 SHALL have port m_valid  out  1: stream valid.
REQ-014 SHALL have port m_ready  in  1: stream ready.
REQ-015 SHALL have port m_last  out  1: marks index 2*P-2.
REQ-016 SHALL have port busy  out  1: unload in progress.
REQ-017 SHALL have port done  out  1: one-cycle pulse after the last beat transfers.

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN, DONE, WAIT_LOW.
REQ-019 IDLE SHALL go to READ on the first cycle ntt_valid=1, with the read counter at 0.
REQ-020 In READ, each cycle SHALL issue one read (ntt_addr=counter, counter+1) only when in-flight reads + FIFO occupancy < FIFO depth; otherwise it SHALL hold ntt_addr and the counter.
REQ-021 A read issued at cycle t SHALL be captured from ntt_dout at cycle t+RD_LAT into a FIFO of depth RD_LAT+2, via an RD_LAT-deep issue-tag shift register.
REQ-022 READ SHALL go to DRAIN in the cycle after address 2*P-2 issues; no address >= 2*P-1 SHALL ever be issued.
REQ-023 DRAIN SHALL go to DONE when the beat with m_last=1 transfers (m_valid & m_ready).
REQ-024 DONE SHALL last exactly one cycle with done=1, then go to WAIT_LOW.
REQ-025 WAIT_LOW SHALL return to IDLE when ntt_valid=0, so that a held-high valid never retriggers.
REQ-026 Centering SHALL output x-Q when x > (Q-1)/2, otherwise x; the result is two's-complement in LG2_Q bits.
REQ-027 The stream SHALL follow valid/ready rules: while m_valid=1 and m_ready=0, m_data, m_index and m_last SHALL stay stable; m_valid SHALL NOT depend combinationally on m_ready.
REQ-028 With m_ready held at 1, throughput SHALL be one beat per cycle after the first beat, and the first beat SHALL appear RD_LAT+1 cycles after leaving IDLE.
REQ-029 Beats SHALL leave in strictly increasing index order 0..2*P-2 with no drops or duplicates under arbitrary m_ready patterns.
REQ-030 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-031 ntt_valid falling during READ or DRAIN SHALL be ignored and the unload SHALL complete.
REQ-032 busy SHALL be 1 in READ and DRAIN and 0 otherwise.

Reset
REQ-033 While rst=0 at a clock edge, the block SHALL enter IDLE, clear counters, tags and FIFO, and drive ntt_addr=0, ntt_input_fg=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, done=0.
REQ-034 Reset asserted mid-unload SHALL abort the unload with no further beats, and after rst returns to 1 the block SHALL wait in IDLE for ntt_valid.

Verification
REQ-035 Bench SHALL cover: NTT model with RD_LAT=4 returning dout=addr, m_ready=1 -> 1521 beats with m_index 0..1520, m_last only at 1520, first beat 5 cycles after valid, done 1 cycle after last.
REQ-036 Bench SHALL cover: dout values 0, 2295, 2296, 4590 -> m_data 0, 2295, -2295, -1.
REQ-037 Bench SHALL cover: m_ready random at 30% duty -> in-order, complete, stable-while-stalled stream, FIFO never overflows, ntt_addr never exceeds 1520.
REQ-038 Bench SHALL cover: m_ready=0 for 50 cycles at start -> exactly RD_LAT+2 reads issued, then a stall with ntt_addr held.
REQ-039 Bench SHALL cover: ntt_valid held high after done -> no second unload; valid dropped then raised -> second full unload.
REQ-040 Bench SHALL cover: rst=0 at beat 700 -> m_valid=0 the next cycle, busy=0, and a new valid produces a fresh unload from index 0.
